pmem_arbiter: RTL and testbench

//  Shares the single burst-mode physical memory port between the I-cache (line read only)
//  and the D-cache (line read/write). Wins arbitration, then splits each cache-line

---
 rtl/pmem_arbiter_pkg.sv | 36 +++
 rtl/pmem_arbiter_if.sv | 56 +++++
 rtl/pmem_arbiter_line_burst_buf.sv | 55 +++++
 rtl/pmem_arbiter.sv | 126 ++++++++++++
 tb/tb_pmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
// ============================================================================
// pmem_arb_pkg : shared types and width helpers for the pmem arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package pmem_arb_pkg;

    localparam int DEF_LINE_WIDTH = 256;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_I_RD = 3'd1,
        ST_D_RD = 3'd2,
        ST_D_WR = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    function automatic int burst_width(input int line_width, input int burst_len);
        return line_width / burst_len;
    endfunction

    function automatic int beat_cnt_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pmem_arbiter_if.sv
// ============================================================================
// pmem_arbiter_if : I-cache, D-cache and burst pmem signals of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface pmem_arbiter_if
    import pmem_arb_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int BURST_WIDTH = burst_width(LINE_WIDTH, BURST_LEN);

    logic                   i_read;
    logic [ADDR_WIDTH-1:0]  i_addr;
    logic [LINE_WIDTH-1:0]  i_rdata;
    logic                   i_resp;

    logic                   d_read;
    logic                   d_write;
    logic [ADDR_WIDTH-1:0]  d_addr;
    logic [LINE_WIDTH-1:0]  d_wdata;
    logic [LINE_WIDTH-1:0]  d_rdata;
    logic                   d_resp;

    logic                   pmem_read;
    logic                   pmem_write;
    logic [ADDR_WIDTH-1:0]  pmem_addr;
    logic [BURST_WIDTH-1:0] pmem_wdata;
    logic [BURST_WIDTH-1:0] pmem_rdata;
    logic                   pmem_resp;
    logic                   pmem_error;

    logic                   arb_error;

    // Arbiter side
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        input  pmem_rdata, pmem_resp, pmem_error,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata, arb_error
    );

    // Caches plus memory side
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        output pmem_rdata, pmem_resp, pmem_error,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata, arb_error
    );

endinterface

`default_nettype wire

// File: rtl/pmem_arbiter_line_burst_buf.sv
// ============================================================================
// line_burst_buf : cache-line register with beat counter and beat mux/demux
// Rev 1.0
// ============================================================================
`default_nettype none

module line_burst_buf
    import pmem_arb_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      load_line,
    input  logic [LINE_WIDTH-1:0]                     line_in,
    input  logic                                      take_beat,
    input  logic                                      store_beat,
    input  logic [burst_width(LINE_WIDTH, BURST_LEN)-1:0] beat_in,
    output logic [burst_width(LINE_WIDTH, BURST_LEN)-1:0] beat_out,
    output logic [LINE_WIDTH-1:0]                     line_out,
    output logic                                      last_beat
);
    localparam int BURST_WIDTH = burst_width(LINE_WIDTH, BURST_LEN);
    localparam int CNT_WIDTH   = beat_cnt_width(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] c_last_cnt = CNT_WIDTH'(BURST_LEN - 1);

    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [LINE_WIDTH-1:0] r_line;

    assign last_beat = (r_cnt == c_last_cnt);
    assign beat_out  = r_line[int'(r_cnt)*BURST_WIDTH +: BURST_WIDTH];
    assign line_out  = r_line;

    // Counter wraps to zero on the final beat so the next burst starts at beat 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else begin
            if (load_line) begin
                r_line <= line_in;
            end
            if (take_beat) begin
                if (store_beat) begin
                    r_line[int'(r_cnt)*BURST_WIDTH +: BURST_WIDTH] <= beat_in;
                end
                r_cnt <= last_beat ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pmem_arbiter.sv
// ============================================================================
// pmem_arbiter : shares one burst pmem port between I-cache and D-cache
// Rev 1.0
// ============================================================================
`default_nettype none

module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    pmem_arbiter_if.slave bus
);
    localparam int BURST_WIDTH = burst_width(LINE_WIDTH, BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] c_line_mask = ~ADDR_WIDTH'(LINE_WIDTH/8 - 1);

    state_t                 r_state, w_state_nxt;
    src_t                   r_src, r_prio, r_hold_src, w_grant_src;
    logic                   r_hold, r_pmem_read, r_pmem_write, r_arb_error;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   w_grant, w_i_req, w_d_req, w_in_burst;
    logic                   w_take_beat, w_last_beat, w_err_evt;
    logic [LINE_WIDTH-1:0]  w_line;
    logic [BURST_WIDTH-1:0] w_beat_out;

    // Requester just served is masked for the one IDLE cycle after RESP
    assign w_i_req = bus.i_read && !(r_hold && r_hold_src == SRC_I);
    assign w_d_req = (bus.d_read || bus.d_write) && !(r_hold && r_hold_src == SRC_D);

    assign w_in_burst  = (r_state == ST_I_RD) || (r_state == ST_D_RD) || (r_state == ST_D_WR);
    assign w_take_beat = w_in_burst && bus.pmem_resp;
    assign w_err_evt   = ((r_state == ST_IDLE) && bus.d_read && bus.d_write)
                       || (bus.pmem_resp && ((r_state == ST_IDLE) || (r_state == ST_RESP)))
                       || bus.pmem_error;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_src = SRC_D;
        case (r_state)
            ST_IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_grant = 1'b1;
                    if (w_i_req && w_d_req) begin
                        w_grant_src = r_prio;
                    end else begin
                        w_grant_src = w_d_req ? SRC_D : SRC_I;
                    end
                    if (w_grant_src == SRC_I) begin
                        w_state_nxt = ST_I_RD;
                    end else begin
                        w_state_nxt = bus.d_write ? ST_D_WR : ST_D_RD;
                    end
                end
            end
            ST_I_RD, ST_D_RD, ST_D_WR: begin
                if (bus.pmem_resp && w_last_beat) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_src        <= SRC_D;
            r_prio       <= SRC_D;
            r_hold       <= 1'b0;
            r_hold_src   <= SRC_D;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_addr       <= '0;
            r_arb_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pmem_read  <= (w_state_nxt == ST_I_RD) || (w_state_nxt == ST_D_RD);
            r_pmem_write <= (w_state_nxt == ST_D_WR);
            r_hold       <= (r_state == ST_RESP);
            r_hold_src   <= r_src;
            if (w_grant) begin
                r_src  <= w_grant_src;
                r_prio <= (w_grant_src == SRC_I) ? SRC_D : SRC_I;
                r_addr <= ((w_grant_src == SRC_I) ? bus.i_addr : bus.d_addr) & c_line_mask;
            end
            if (w_err_evt) begin
                r_arb_error <= 1'b1;
            end
        end
    end

    line_burst_buf #(
        .LINE_WIDTH (LINE_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .load_line  (w_grant && (w_state_nxt == ST_D_WR)),
        .line_in    (bus.d_wdata),
        .take_beat  (w_take_beat),
        .store_beat (r_state != ST_D_WR),
        .beat_in    (bus.pmem_rdata),
        .beat_out   (w_beat_out),
        .line_out   (w_line),
        .last_beat  (w_last_beat)
    );

    assign bus.i_resp     = (r_state == ST_RESP) && (r_src == SRC_I);
    assign bus.d_resp     = (r_state == ST_RESP) && (r_src == SRC_D);
    assign bus.i_rdata    = w_line;
    assign bus.d_rdata    = w_line;
    assign bus.pmem_read  = r_pmem_read;
    assign bus.pmem_write = r_pmem_write;
    assign bus.pmem_addr  = r_addr;
    assign bus.pmem_wdata = w_beat_out;
    assign bus.arb_error  = r_arb_error;

endmodule

`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
// ============================================================================
// tb_pmem_arbiter : randomized bench with line-level memory and arbitration model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pmem_arbiter;
    import pmem_arb_pkg::*;

    localparam int LW  = 256;
    localparam int BL  = 4;
    localparam int AW  = 32;
    localparam int BW  = LW / BL;
    localparam int TMO = 400;
    localparam logic [AW-1:0] LINE_MASK = ~AW'(LW/8 - 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.LINE_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) bus ();

    pmem_arbiter #(.LINE_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [LW-1:0] pm_mem  [logic [AW-1:0]];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];
    logic [AW-1:0] last_burst_addr = '0;
    int            bursts      = 0;
    int            beats_taken = 0;
    bit            stray_req   = 1'b0;
    byte           served_q[$];

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < BL; k++) begin
            l[k*BW +: BW] = BW'({a, (32'(k) * 32'h0101_0101) ^ 32'h5A00_00C3});
        end
        return l;
    endfunction

    function automatic logic [LW-1:0] pm_line(input logic [AW-1:0] a);
        return pm_mem.exists(a) ? pm_mem[a] : init_line(a);
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW/32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Memory model: random per-beat delay, beats land in line order
    initial begin
        bit            active_q = 1'b0;
        int            beat     = 0;
        logic [LW-1:0] line;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !(bus.pmem_read || bus.pmem_write)) begin
                bus.pmem_resp = stray_req;
                stray_req     = 1'b0;
                beat          = 0;
                active_q      = 1'b0;
            end else begin
                if (!active_q) begin
                    bursts++;
                    last_burst_addr = bus.pmem_addr;
                    active_q        = 1'b1;
                end
                bus.pmem_resp = ($urandom_range(0, 2) != 0);
                if (bus.pmem_resp) begin
                    check_eq("pmem_addr_steady", LW'(bus.pmem_addr), LW'(last_burst_addr));
                    line = pm_line(bus.pmem_addr);
                    if (bus.pmem_write) begin
                        line[beat*BW +: BW] = bus.pmem_wdata;
                        pm_mem[bus.pmem_addr] = line;
                    end else begin
                        bus.pmem_rdata = line[beat*BW +: BW];
                    end
                    beat = (beat + 1) % BL;
                    beats_taken++;
                end
            end
        end
    end

    task automatic i_request(input logic [AW-1:0] addr, input int hold_extra);
        logic [LW-1:0] exp;
        int t;
        exp = ref_line(addr & LINE_MASK);
        bus.i_addr = addr;
        bus.i_read = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!bus.i_resp && t < TMO);
        check_eq("i_resp_seen", LW'(bus.i_resp), LW'(1));
        check_eq("i_rdata", bus.i_rdata, exp);
        check_eq("i_resp_excl", LW'({bus.d_resp, bus.pmem_read, bus.pmem_write}), '0);
        served_q.push_back("I");
        if (hold_extra == 0) bus.i_read = 1'b0;
        tick();
        check_eq("i_resp_pulse", LW'(bus.i_resp), '0);
        if (hold_extra > 1) repeat (hold_extra - 1) tick();
        bus.i_read = 1'b0;
    endtask

    // mode: 0 read, 1 write, 2 read+write asserted together
    task automatic d_request(input logic [AW-1:0] addr, input int mode, input logic [LW-1:0] wdata);
        logic [AW-1:0] la;
        logic [LW-1:0] exp;
        int t;
        la  = addr & LINE_MASK;
        exp = ref_line(la);
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_read  = (mode != 1);
        bus.d_write = (mode != 0);
        t = 0;
        do begin tick(); t++; end while (!bus.d_resp && t < TMO);
        check_eq("d_resp_seen", LW'(bus.d_resp), LW'(1));
        check_eq("d_resp_excl", LW'({bus.i_resp, bus.pmem_read, bus.pmem_write}), '0);
        if (mode == 0) begin
            check_eq("d_rdata", bus.d_rdata, exp);
        end else begin
            check_eq("d_wr_line", pm_line(la), wdata);
            ref_mem[la] = wdata;
        end
        served_q.push_back("D");
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        tick();
        check_eq("d_resp_pulse", LW'(bus.d_resp), '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        byte exp_src;
        int  b0;
        rst = 1'b1;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.pmem_error = 1'b0;
        repeat (2) tick();
        check_eq("rst_ctrl", LW'({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write,
                                  bus.arb_error, bus.pmem_addr, bus.pmem_wdata}), '0);
        check_eq("rst_line", bus.i_rdata, '0);

        // Contention straight out of reset, then sustained contention
        rst = 1'b0;
        exp_src = "I";
        served_q.delete();
        fork
            i_request(32'h0000_1100, 0);
            d_request(32'h0000_0020, 0, '0);
        join
        fork
            begin i_request(32'h0000_1140, 0); i_request(32'h0000_1160, 0); end
            begin d_request(32'h0000_0060, 0, '0); d_request(32'h0000_0080, 0, '0); end
        join
        foreach (served_q[k]) begin
            exp_src = (exp_src == "D") ? "I" : "D";
            check_eq("grant_order", LW'(served_q[k]), LW'(exp_src));
        end
        check_eq("grant_count", LW'(served_q.size()), LW'(6));

        // Single I read, unaligned address
        i_request(32'h0000_1234, 0);
        check_eq("i_pmem_addr", LW'(last_burst_addr), LW'(32'h0000_1220));

        // D write then readback
        d_request(32'h0000_0040, 1, {64'hD, 64'hC, 64'hB, 64'hA});
        d_request(32'h0000_0040, 0, '0);

        // Held request after resp yields exactly one burst
        b0 = bursts;
        i_request(32'h0000_1800, 2);
        repeat (4) tick();
        check_eq("one_burst", LW'(bursts - b0), LW'(1));

        // Random traffic from both caches
        served_q.delete();
        fork
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(0, 4)) tick();
                i_request(32'h0000_1000 + AW'($urandom_range(0, 4095)), 0);
            end
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(0, 4)) tick();
                d_request(AW'($urandom_range(0, 255)), int'($urandom_range(0, 1)), rand_line());
            end
        join
        check_eq("no_err_legal", LW'(bus.arb_error), '0);

        // Reset in the middle of a D read burst
        bus.d_addr = 32'h0000_0200;
        bus.d_read = 1'b1;
        beats_taken = 0;
        for (int t = 0; t < TMO && beats_taken < 2; t++) tick();
        rst = 1'b1;
        bus.d_read = 1'b0;
        tick();
        check_eq("rst_mid_ctrl", LW'({bus.pmem_read, bus.pmem_write, bus.d_resp}), '0);
        rst = 1'b0;
        tick();
        check_eq("rst_mid_idle", LW'({bus.pmem_read, bus.pmem_write, bus.d_resp}), '0);
        i_request(32'h0000_1480, 0);

        // Illegal cases and sticky error
        d_request(32'h0000_0300, 2, rand_line());
        check_eq("err_rw_both", LW'(bus.arb_error), LW'(1));
        repeat (5) tick();
        check_eq("err_sticky", LW'(bus.arb_error), LW'(1));
        d_request(32'h0000_0300, 0, '0);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check_eq("err_cleared", LW'(bus.arb_error), '0);
        stray_req = 1'b1;
        repeat (3) tick();
        check_eq("err_stray_resp", LW'(bus.arb_error), LW'(1));
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check_eq("err_cleared2", LW'(bus.arb_error), '0);
        fork
            i_request(32'h0000_1700, 0);
            begin repeat (3) tick(); bus.pmem_error = 1'b1; tick(); bus.pmem_error = 1'b0; end
        join
        check_eq("err_pmem_error", LW'(bus.arb_error), LW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
